// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: word width, op codes,
// FSM state encodings and a small magnitude helper.
package hilo_muldiv_unit_pkg;

   localparam int WORD_LEN  = 32;
   localparam int MD_OP_LEN = 3;
   localparam int CNT_W     = $clog2(WORD_LEN);

   typedef logic [WORD_LEN-1:0] word_t;

   localparam logic [MD_OP_LEN-1:0] MD_MULT  = 3'd0;
   localparam logic [MD_OP_LEN-1:0] MD_MULTU = 3'd1;
   localparam logic [MD_OP_LEN-1:0] MD_DIV   = 3'd2;
   localparam logic [MD_OP_LEN-1:0] MD_DIVU  = 3'd3;
   localparam logic [MD_OP_LEN-1:0] MD_MTHI  = 3'd4;
   localparam logic [MD_OP_LEN-1:0] MD_MTLO  = 3'd5;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   // Absolute value of a word when treated as signed; unsigned ops pass through.
   function automatic word_t magnitude(input word_t val, input logic is_neg);
      return is_neg ? word_t'(-val) : val;
   endfunction

endpackage

// File: rtl/hilo_muldiv_unit_core.sv
// One iteration of the shared multiply/divide datapath. The accumulator is
// {upper, lower}: for multiply upper collects partial products while lower
// holds the remaining multiplier bits; for divide upper is the running
// remainder and lower shifts dividend bits out / quotient bits in.
module hilo_muldiv_unit_core
   import hilo_muldiv_unit_pkg::*;
(
   input  logic                  is_div,
   input  logic [2*WORD_LEN-1:0] acc,
   input  logic [WORD_LEN-1:0]   operand,
   output logic [2*WORD_LEN-1:0] acc_next
);

   logic [WORD_LEN:0] add_sum;
   logic [WORD_LEN:0] rem_shift;
   logic [WORD_LEN:0] rem_diff;

   // Add-shift for multiply, restoring sub-shift for divide.
   always_comb begin
      add_sum   = {1'b0, acc[2*WORD_LEN-1:WORD_LEN]} + {1'b0, operand};
      // remainder shifted left with the next dividend bit appended
      rem_shift = acc[2*WORD_LEN-1:WORD_LEN-1];
      rem_diff  = rem_shift - {1'b0, operand};
      acc_next  = acc;
      if (is_div) begin
         if (!rem_diff[WORD_LEN]) begin
            acc_next = {rem_diff[WORD_LEN-1:0], acc[WORD_LEN-2:0], 1'b1};
         end else begin
            acc_next = {rem_shift[WORD_LEN-1:0], acc[WORD_LEN-2:0], 1'b0};
         end
      end else if (acc[0]) begin
         acc_next = {add_sum, acc[WORD_LEN-1:1]};
      end else begin
         acc_next = {1'b0, acc[2*WORD_LEN-1:1]};
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit with the architectural HI/LO registers.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  ST_IDLE   | waiting for an op; MTHI/MTLO and divide-by-zero handled here
//  ST_RUN    | WORD_LEN iterations of the core, counter counts down to 0
//  ST_FINISH | sign fix-up of the result and HI/LO write
module hilo_muldiv_unit
   import hilo_muldiv_unit_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [MD_OP_LEN-1:0] op,
   input  logic [WORD_LEN-1:0]  rs_val,
   input  logic [WORD_LEN-1:0]  rt_val,
   input  logic                 flush,
   output logic                 busy,
   output logic                 done,
   output logic                 div_by_zero,
   output logic [WORD_LEN-1:0]  hi,
   output logic [WORD_LEN-1:0]  lo
);

   logic [1:0]            state;
   logic [CNT_W-1:0]      iter_cnt;
   logic [2*WORD_LEN-1:0] acc;
   logic [2*WORD_LEN-1:0] acc_next;
   logic [WORD_LEN-1:0]   operand_q;
   logic                  is_div_q;
   logic                  res_neg_q;
   logic                  rem_neg_q;

   logic                  is_muldiv_op;
   logic                  is_div_op;
   logic                  signed_op;
   logic                  rs_neg;
   logic                  rt_neg;
   word_t                 rs_mag;
   word_t                 rt_mag;
   logic                  div_zero;
   logic [2*WORD_LEN-1:0] prod_signed;
   logic [WORD_LEN-1:0]   quot_signed;
   logic [WORD_LEN-1:0]   rem_signed;

   // Decode the incoming op and reduce signed operands to magnitudes.
   always_comb begin
      is_muldiv_op = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
      is_div_op    = (op == MD_DIV) || (op == MD_DIVU);
      signed_op    = (op == MD_MULT) || (op == MD_DIV);
      rs_neg       = signed_op && rs_val[WORD_LEN-1];
      rt_neg       = signed_op && rt_val[WORD_LEN-1];
      rs_mag       = magnitude(rs_val, rs_neg);
      rt_mag       = magnitude(rt_val, rt_neg);
      div_zero     = is_div_op && (rt_val == '0);
   end

   // Final sign correction; quotient of most-negative by -1 wraps naturally.
   always_comb begin
      prod_signed = res_neg_q ? (2*WORD_LEN)'(-acc) : acc;
      quot_signed = res_neg_q ? WORD_LEN'(-acc[WORD_LEN-1:0]) : acc[WORD_LEN-1:0];
      rem_signed  = rem_neg_q ? WORD_LEN'(-acc[2*WORD_LEN-1:WORD_LEN]) : acc[2*WORD_LEN-1:WORD_LEN];
   end

   hilo_muldiv_unit_core u_core (
      .is_div   (is_div_q),
      .acc      (acc),
      .operand  (operand_q),
      .acc_next (acc_next)
   );

   // Control FSM, iteration counter, operand latches and HI/LO registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         iter_cnt    <= '0;
         acc         <= '0;
         operand_q   <= '0;
         is_div_q    <= 1'b0;
         res_neg_q   <= 1'b0;
         rem_neg_q   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     if (is_muldiv_op) begin
                        if (div_zero) begin
                           done        <= 1'b1;
                           div_by_zero <= 1'b1;
                        end else begin
                           state     <= ST_RUN;
                           busy      <= 1'b1;
                           iter_cnt  <= CNT_W'(WORD_LEN - 1);
                           is_div_q  <= is_div_op;
                           res_neg_q <= rs_neg ^ rt_neg;
                           rem_neg_q <= rs_neg;
                           if (is_div_op) begin
                              acc       <= {{WORD_LEN{1'b0}}, rs_mag};
                              operand_q <= rt_mag;
                           end else begin
                              acc       <= {{WORD_LEN{1'b0}}, rt_mag};
                              operand_q <= rs_mag;
                           end
                        end
                     end else if (op == MD_MTHI) begin
                        hi <= rs_val;
                     end else if (op == MD_MTLO) begin
                        lo <= rs_val;
                     end
                  end
               end
               ST_RUN: begin
                  acc <= acc_next;
                  if (iter_cnt == '0) begin
                     state <= ST_FINISH;
                     done  <= 1'b1;
                  end else begin
                     iter_cnt <= iter_cnt - CNT_W'(1);
                  end
               end
               ST_FINISH: begin
                  if (is_div_q) begin
                     hi <= rem_signed;
                     lo <= quot_signed;
                  end else begin
                     hi <= prod_signed[2*WORD_LEN-1:WORD_LEN];
                     lo <= prod_signed[WORD_LEN-1:0];
                  end
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit. Inputs change and outputs are sampled
// 1 time unit after each rising edge; "cycle n" is the interval after edge n
// counted from the edge that accepts start.
module tb_hilo_muldiv_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        flush;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   hilo_muldiv_unit dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .flush       (flush),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one mult/div op and follow it to completion.
   task automatic md_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      step();
      start = 1'b0;
      n = 1;
      check({tag, "_busy_c1"}, {31'd0, busy}, 32'd1);
      while (!done && n < 40) begin
         step();
         n++;
      end
      check({tag, "_done_cycle"}, 32'(n), 32'd33);
      check({tag, "_busy_c33"}, {31'd0, busy}, 32'd1);
      step();
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      check({tag, "_busy_c34"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n_done;
      reset  = 1'b1;
      start  = 1'b0;
      op     = 3'd0;
      rs_val = '0;
      rt_val = '0;
      flush  = 1'b0;
      step();
      step();
      reset = 1'b0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);

      md_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      md_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      md_op("mult_maxneg1", 3'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001);
      md_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
      md_op("divu_big", 3'd3, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF);
      md_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      md_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
      md_op("div_wrap", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

      // divide by zero: immediate pulses, no busy, HI/LO untouched
      start  = 1'b1;
      op     = 3'd2;
      rs_val = 32'd5;
      rt_val = 32'd0;
      step();
      start = 1'b0;
      check("dbz_flag_c1", {31'd0, div_by_zero}, 32'd1);
      check("dbz_done_c1", {31'd0, done}, 32'd1);
      check("dbz_busy_c1", {31'd0, busy}, 32'd0);
      step();
      check("dbz_flag_c2", {31'd0, div_by_zero}, 32'd0);
      check("dbz_done_c2", {31'd0, done}, 32'd0);
      check("dbz_busy_c2", {31'd0, busy}, 32'd0);
      check("dbz_hi", hi, 32'd0);
      check("dbz_lo", lo, 32'h8000_0000);

      // MTHI / MTLO
      start  = 1'b1;
      op     = 3'd4;
      rs_val = 32'h1234;
      step();
      check("mthi_hi", hi, 32'h1234);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      check("mthi_done", {31'd0, done}, 32'd0);
      op     = 3'd5;
      rs_val = 32'h5678;
      step();
      start = 1'b0;
      check("mtlo_lo", lo, 32'h5678);
      check("mtlo_hi_kept", hi, 32'h1234);

      // MTLO while busy is ignored
      start  = 1'b1;
      op     = 3'd0;
      rs_val = 32'd2;
      rt_val = 32'd3;
      step();
      op     = 3'd5;
      rs_val = 32'hDEAD;
      step();
      start = 1'b0;
      check("mtlo_busy_lo", lo, 32'h5678);
      check("run_hold_hi", hi, 32'h1234);
      n_done = 2;
      while (!done && n_done < 40) begin
         step();
         n_done++;
      end
      check("mult23_done_cycle", 32'(n_done), 32'd33);
      step();
      check("mult23_hi", hi, 32'd0);
      check("mult23_lo", lo, 32'd6);

      // flush at cycle 10: back to idle, HI/LO kept, no done afterwards
      start  = 1'b1;
      op     = 3'd0;
      rs_val = 32'd5;
      rt_val = 32'd5;
      step();
      start = 1'b0;
      repeat (9) step();
      check("flush_busy_before", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      n_done = 0;
      repeat (40) begin
         if (done) n_done++;
         step();
      end
      check("flush_no_done", 32'(n_done), 32'd0);
      check("flush_hi", hi, 32'd0);
      check("flush_lo", lo, 32'd6);

      // flush together with start: op not accepted
      start  = 1'b1;
      flush  = 1'b1;
      op     = 3'd0;
      step();
      check("flush_start_busy", {31'd0, busy}, 32'd0);
      op     = 3'd4;
      rs_val = 32'h99;
      step();
      start = 1'b0;
      flush = 1'b0;
      check("flush_mthi_hi", hi, 32'd0);

      // reset at cycle 10 of a multiply
      md_op("mult_pre", 3'd1, 32'd9, 32'd9, 32'd0, 32'd81);
      start  = 1'b1;
      op     = 3'd0;
      rs_val = 32'd4;
      rt_val = 32'd4;
      step();
      start = 1'b0;
      repeat (9) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_hi", hi, 32'd0);
      check("midrst_lo", lo, 32'd0);

      md_op("mult_negneg", 3'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd0, 32'd25);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
